hdmi_tx_i2c_cfg: RTL and testbench

- Configuration sequencer for the HDMI transmitter (ADV7513-class) on the HDMI_I2C_SCL/SDA pins.
- Sits alongside the video pattern generator. It powers up and programs the transmitter so that the 24-bit RGB, DE/HS/VS stream from the pattern generator is accepted and driven as HDMI.
- Runs a fixed register-write table over I2C after reset, on request, and whenever the transmitter raises HDMI_TX_INT (hot-plug). Reports busy/done/error.

---
 rtl/hdmi_tx_cfg_pkg.sv | 22 ++
 rtl/hdmi_tx_cfg_rom.sv | 29 ++
 rtl/hdmi_tx_i2c_cfg.sv | 232 +++++++++++++++++++++++
 tb/tb_hdmi_tx_i2c_cfg.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_tx_cfg_pkg.sv
// Shared types for the HDMI transmitter I2C configuration sequencer.
package hdmi_tx_cfg_pkg;

  localparam int NUM_REGS = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BYTE,
    ST_ACK,
    ST_STOP,
    ST_GAP,
    ST_NEXT,
    ST_FIN
  } cfg_state_t;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } cfg_entry_t;

endpackage

// File: rtl/hdmi_tx_cfg_rom.sv
// Fixed register-write table that brings the transmitter up for 24-bit RGB input.
module hdmi_tx_cfg_rom
  import hdmi_tx_cfg_pkg::*;
(
  input  logic [4:0] index,
  output cfg_entry_t entry
);

  always_comb begin
    entry = '{reg_addr: 8'h00, data: 8'h00};
    case (index)
      5'd0:  entry = '{reg_addr: 8'h41, data: 8'h10};
      5'd1:  entry = '{reg_addr: 8'h98, data: 8'h03};
      5'd2:  entry = '{reg_addr: 8'h9A, data: 8'hE0};
      5'd3:  entry = '{reg_addr: 8'h9C, data: 8'h30};
      5'd4:  entry = '{reg_addr: 8'h9D, data: 8'h61};
      5'd5:  entry = '{reg_addr: 8'hA2, data: 8'hA4};
      5'd6:  entry = '{reg_addr: 8'hA3, data: 8'hA4};
      5'd7:  entry = '{reg_addr: 8'hE0, data: 8'hD0};
      5'd8:  entry = '{reg_addr: 8'hF9, data: 8'h00};
      5'd9:  entry = '{reg_addr: 8'h15, data: 8'h00};
      5'd10: entry = '{reg_addr: 8'h16, data: 8'h30};
      5'd11: entry = '{reg_addr: 8'hAF, data: 8'h06};
      5'd12: entry = '{reg_addr: 8'hD6, data: 8'hC0};
      default: ;
    endcase
  end

endmodule

// File: rtl/hdmi_tx_i2c_cfg.sv
// I2C write sequencer that programs the HDMI transmitter after reset, on request
// and on hot-plug interrupts. SCL/SDA outputs are open-drain pull-down enables.
//
// state | meaning
// IDLE  | bus released, waiting for a pending start on a tick
// START | ph1 SDA low with SCL high, ph3 SCL low
// BYTE  | 8 bits MSB first, 4 phases per bit
// ACK   | SDA released, slave level sampled in ph2
// STOP  | SDA rises with SCL high; exit picks next entry, retry gap or finish
// GAP   | RETRY_GAP released ticks before retrying the same entry
// NEXT  | folded into the STOP exit so entries run back to back
// FIN   | folded into the STOP exit of the last entry
module hdmi_tx_i2c_cfg
  import hdmi_tx_cfg_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 3,
  parameter logic [7:0]  DEV_ADDR  = 8'h72,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned RETRY_GAP = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       init_req,
  input  logic       tx_int_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [4:0] err_index
);

  localparam logic [7:0] DIV_LAST    = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST    = 8'(RETRY_GAP - 1);
  localparam logic [3:0] ATTEMPT_MAX = 4'(MAX_RETRY + 1);
  localparam logic [4:0] LAST_INDEX  = 5'(NUM_REGS - 1);

  cfg_state_t state, state_nxt;
  cfg_entry_t entry;

  logic [7:0] div_cnt;
  logic       tick;
  logic       int_s1, int_s2, int_prev, int_fall;
  logic       pending, start_seq;
  logic [1:0] ph;
  logic [2:0] bit_cnt;
  logic [1:0] byte_sel;
  logic [4:0] index;
  logic       nack;
  logic [3:0] nack_cnt;
  logic [7:0] gap_cnt;
  logic [7:0] cur_byte;
  logic       phase_state, stretch, adv, last_entry;

  hdmi_tx_cfg_rom u_rom (
    .index (index),
    .entry (entry)
  );

  // Free-running divider; never restarted so sequences align to the existing tick grid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  div_cnt <= 8'd0;
    else if (tick) div_cnt <= 8'd0;
    else           div_cnt <= div_cnt + 8'd1;
  end
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_s1   <= 1'b1;
      int_s2   <= 1'b1;
      int_prev <= 1'b1;
    end else begin
      int_s1   <= tx_int_n;
      int_s2   <= int_s1;
      int_prev <= int_s2;
    end
  end
  assign int_fall = int_prev & ~int_s2;

  assign start_seq = (state == ST_IDLE) && tick && pending;

  // Reset leaves a start pending so the table is written right after power-up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 pending <= 1'b1;
    else if (init_req || int_fall) pending <= 1'b1;
    else if (start_seq)           pending <= 1'b0;
  end

  always_comb begin
    case (byte_sel)
      2'd0:    cur_byte = DEV_ADDR;
      2'd1:    cur_byte = entry.reg_addr;
      default: cur_byte = entry.data;
    endcase
  end

  assign phase_state = (state == ST_START) || (state == ST_BYTE) ||
                       (state == ST_ACK)   || (state == ST_STOP);
  // SCL is released in every ph2, so a low pad there means the slave is stretching.
  assign stretch     = phase_state && (ph == 2'd2) && !scl_in;
  assign adv         = tick && !stretch;
  assign last_entry  = (index == LAST_INDEX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_seq) state_nxt = ST_START;
      ST_START: if (adv && ph == 2'd3) state_nxt = ST_BYTE;
      ST_BYTE:  if (adv && ph == 2'd3 && bit_cnt == 3'd0) state_nxt = ST_ACK;
      ST_ACK: begin
        if (adv && ph == 2'd3)
          state_nxt = (nack || byte_sel == 2'd2) ? ST_STOP : ST_BYTE;
      end
      ST_STOP: begin
        if (adv && ph == 2'd3) begin
          if (nack)            state_nxt = (nack_cnt >= ATTEMPT_MAX) ? ST_IDLE : ST_GAP;
          else if (last_entry) state_nxt = ST_IDLE;
          else                 state_nxt = ST_START;
        end
      end
      ST_GAP:   if (tick && gap_cnt == 8'd0) state_nxt = ST_START;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph        <= 2'd0;
      bit_cnt   <= 3'd7;
      byte_sel  <= 2'd0;
      index     <= 5'd0;
      nack      <= 1'b0;
      nack_cnt  <= 4'd0;
      gap_cnt   <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_index <= 5'd0;
    end else begin
      if (adv && phase_state) ph <= ph + 2'd1;
      case (state)
        ST_IDLE: begin
          if (start_seq) begin
            index    <= 5'd0;
            nack     <= 1'b0;
            nack_cnt <= 4'd0;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
          end
        end
        ST_START: begin
          if (adv && ph == 2'd3) begin
            bit_cnt  <= 3'd7;
            byte_sel <= 2'd0;
          end
        end
        ST_BYTE: begin
          if (adv && ph == 2'd3 && bit_cnt != 3'd0) bit_cnt <= bit_cnt - 3'd1;
        end
        ST_ACK: begin
          if (adv && ph == 2'd2) nack <= sda_in;
          if (adv && ph == 2'd3) begin
            if (nack) nack_cnt <= nack_cnt + 4'd1;
            else if (byte_sel != 2'd2) begin
              byte_sel <= byte_sel + 2'd1;
              bit_cnt  <= 3'd7;
            end
          end
        end
        ST_STOP: begin
          if (adv && ph == 2'd3) begin
            nack <= 1'b0;
            if (nack) begin
              if (nack_cnt >= ATTEMPT_MAX) begin
                err       <= 1'b1;
                err_index <= index;
                busy      <= 1'b0;
              end else begin
                gap_cnt <= GAP_LAST;
              end
            end else begin
              nack_cnt <= 4'd0;
              if (last_entry) begin
                done <= 1'b1;
                busy <= 1'b0;
              end else begin
                index <= index + 5'd1;
              end
            end
          end
        end
        ST_GAP: begin
          if (tick && gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state)
      ST_START: begin
        sda_oe = (ph != 2'd0);
        scl_oe = (ph == 2'd3);
      end
      ST_BYTE: begin
        sda_oe = ~cur_byte[bit_cnt];
        scl_oe = (ph == 2'd0) || (ph == 2'd3);
      end
      ST_ACK: begin
        scl_oe = (ph == 2'd0) || (ph == 2'd3);
      end
      ST_STOP: begin
        sda_oe = (ph != 2'd3);
        scl_oe = (ph == 2'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hdmi_tx_i2c_cfg.sv
// Directed bench for hdmi_tx_i2c_cfg with an open-drain bus and a behavioural I2C slave.
module tb_hdmi_tx_i2c_cfg;

  logic       clk = 1'b0;
  logic       reset_n, init_req, tx_int_n;
  logic       scl_in, sda_in, scl_oe, sda_oe;
  logic       busy, done, err;
  logic [4:0] err_index;

  int checks = 0;
  int errors = 0;

  // slave model state
  logic       slv_clr = 1'b0;
  int         nack_mode = 0;
  logic       stretch_req = 1'b0;
  logic       stretch_used = 1'b0;
  int         hold_cnt = 0;
  logic       sda_drv = 1'b0;
  logic       ack_slot = 1'b0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic       scl_now, sda_now, nack_this;
  logic [7:0] shreg = 8'h00;
  int         sbit_cnt = 0;
  int         byte_idx = 0;
  int         start_cnt = 0;
  int         stop_cnt = 0;
  logic [7:0] logb[$];

  always #5 clk = ~clk;

  assign scl_in = !scl_oe && (hold_cnt == 0);
  assign sda_in = !sda_oe && !sda_drv;

  hdmi_tx_i2c_cfg dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .init_req  (init_req),
    .tx_int_n  (tx_int_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_index (err_index)
  );

  // Slave: watches the bus on falling clk edges, logs bytes, ACKs, optionally NACKs or stretches.
  initial forever begin
    @(negedge clk);
    if (slv_clr) begin
      hold_cnt = 0; sda_drv = 1'b0; ack_slot = 1'b0; stretch_used = 1'b0;
      prev_scl = 1'b1; prev_sda = 1'b1; shreg = 8'h00;
      sbit_cnt = 0; byte_idx = 0; start_cnt = 0; stop_cnt = 0;
      logb.delete();
    end else begin
      if (hold_cnt > 0) hold_cnt = hold_cnt - 1;
      scl_now = !scl_oe && (hold_cnt == 0);
      sda_now = !sda_oe && !sda_drv;
      if (prev_scl && scl_now && prev_sda && !sda_now) begin
        start_cnt = start_cnt + 1;
        sbit_cnt = 0; byte_idx = 0; ack_slot = 1'b0; sda_drv = 1'b0;
      end else if (prev_scl && scl_now && !prev_sda && sda_now) begin
        stop_cnt = stop_cnt + 1;
      end else if (!prev_scl && scl_now) begin
        if (!ack_slot) begin
          shreg = {shreg[6:0], sda_now};
          sbit_cnt = sbit_cnt + 1;
        end
      end else if (prev_scl && !scl_now) begin
        if (ack_slot) begin
          ack_slot = 1'b0; sda_drv = 1'b0; sbit_cnt = 0; byte_idx = byte_idx + 1;
        end else if (sbit_cnt == 8) begin
          logb.push_back(shreg);
          nack_this = (nack_mode == 1 && byte_idx == 0 && start_cnt == 3) ||
                      (nack_mode == 2 && byte_idx == 1 && shreg == 8'hA2);
          ack_slot = 1'b1;
          sda_drv = !nack_this;
        end else if (stretch_req && !stretch_used && byte_idx == 2 && sbit_cnt == 4) begin
          hold_cnt = 30;
          stretch_used = 1'b1;
        end
      end
      prev_scl = scl_now;
      prev_sda = sda_now;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy(input logic lvl, input int max, output int n);
    n = 0;
    while (busy !== lvl && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse_init();
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
  endtask

  task automatic clear_slave();
    @(posedge clk);
    slv_clr = 1'b1;
    @(posedge clk);
    slv_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n1, n2, n3;
    reset_n = 1'b0; init_req = 1'b0; tx_int_n = 1'b1;
    #12;
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_index", err_index, 0);

    // power-up sequence, always ACK
    @(negedge clk);
    reset_n = 1'b1;
    wait_busy(1'b1, 10, n1);
    chk("t1_busy_rise", busy, 1);
    chk("t1_rise_clk", n1, 3);
    wait_busy(1'b0, 6000, n2);
    chk("t1_busy_fall", busy, 0);
    chk("t1_dur", n2, 4524);
    chk("t1_total_window", (n1 + n2 >= 4524) && (n1 + n2 <= 4527), 1);
    chk("t1_done", done, 1);
    chk("t1_err", err, 0);
    chk("t1_starts", start_cnt, 13);
    chk("t1_stops", stop_cnt, 13);
    chk("t1_nbytes", logb.size(), 39);
    chk("t1_b0", logb[0], 8'h72);
    chk("t1_b1", logb[1], 8'h41);
    chk("t1_b2", logb[2], 8'h10);
    chk("t1_b36", logb[36], 8'h72);
    chk("t1_b37", logb[37], 8'hD6);
    chk("t1_b38", logb[38], 8'hC0);

    // single address NACK on entry 2
    clear_slave();
    nack_mode = 1;
    pulse_init();
    wait_busy(1'b1, 10, n1);
    chk("t2_busy_rise", busy, 1);
    chk("t2_done_cleared", done, 0);
    wait_busy(1'b0, 6000, n2);
    chk("t2_dur", n2, 4524 + 324);
    chk("t2_done", done, 1);
    chk("t2_err", err, 0);
    chk("t2_starts", start_cnt, 14);
    chk("t2_nbytes", logb.size(), 40);
    chk("t2_nacked_addr", logb[6], 8'h72);
    chk("t2_retry_reg", logb[8], 8'h9A);
    chk("t2_retry_data", logb[9], 8'hE0);
    chk("t2_last", logb[39], 8'hC0);

    // persistent NACK on register A2 (entry 5)
    clear_slave();
    nack_mode = 2;
    pulse_init();
    wait_busy(1'b1, 10, n1);
    chk("t3_busy_rise", busy, 1);
    wait_busy(1'b0, 6000, n2);
    chk("t3_dur", n2, 3276);
    chk("t3_err", err, 1);
    chk("t3_err_index", err_index, 5);
    chk("t3_done", done, 0);
    chk("t3_starts", start_cnt, 9);
    repeat (600) @(negedge clk);
    chk("t3_no_more_starts", start_cnt, 9);
    chk("t3_idle", busy, 0);

    // hot-plug interrupt mid-sequence
    clear_slave();
    nack_mode = 0;
    pulse_init();
    wait_busy(1'b1, 10, n1);
    chk("t4_err_cleared", err, 0);
    repeat (1000) @(negedge clk);
    tx_int_n = 1'b0;
    repeat (2) @(negedge clk);
    tx_int_n = 1'b1;
    wait_busy(1'b0, 6000, n2);
    chk("t4_first_done", done, 1);
    chk("t4_first_starts", start_cnt, 13);
    wait_busy(1'b1, 10, n3);
    chk("t4_restart_clk", n3, 3);
    chk("t4_done_dropped", done, 0);
    wait_busy(1'b0, 6000, n2);
    chk("t4_second_dur", n2, 4524);
    chk("t4_second_done", done, 1);
    chk("t4_total_starts", start_cnt, 26);
    chk("t4_nbytes", logb.size(), 78);

    // clock stretch on bit 3 of entry 0 data byte
    clear_slave();
    stretch_req = 1'b1;
    pulse_init();
    wait_busy(1'b1, 10, n1);
    wait_busy(1'b0, 6000, n2);
    stretch_req = 1'b0;
    chk("t5_stretch_seen", stretch_used, 1);
    chk("t5_done", done, 1);
    chk("t5_starts", start_cnt, 13);
    chk("t5_data_byte", logb[2], 8'h10);
    chk("t5_nbytes", logb.size(), 39);
    chk("t5_shifted", (n2 > 4524) && (n2 <= 4524 + 36), 1);
    chk("t5_tick_aligned", n2 % 3, 0);

    // asynchronous reset in the middle of a byte
    clear_slave();
    pulse_init();
    n1 = 0;
    while ((sbit_cnt < 1 || sda_oe !== 1'b1 || scl_oe !== 1'b1) && n1 < 300) begin
      @(negedge clk);
      n1++;
    end
    chk("t6_pre_sda_oe", sda_oe, 1);
    chk("t6_pre_scl_oe", scl_oe, 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_async_scl_oe", scl_oe, 0);
    chk("t6_async_sda_oe", sda_oe, 0);
    chk("t6_async_busy", busy, 0);
    clear_slave();
    reset_n = 1'b1;
    wait_busy(1'b1, 10, n1);
    chk("t6_restart_clk", n1, 3);
    n2 = 0;
    while (logb.size() < 3 && n2 < 400) begin
      @(negedge clk);
      n2++;
    end
    chk("t6_b0", logb[0], 8'h72);
    chk("t6_b1", logb[1], 8'h41);
    chk("t6_b2", logb[2], 8'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
